// File: rtl/ioctrl_host.sv
// ioctrl_host: host-side bus master for the I/O chip emulation.
// On each START rising edge it writes the held MODE nibble to chip address
// 0x08, pulses UPDATE, waits for the chip to settle, and burst-reads the
// nibble RAM into shadow registers. The shadows are then published on
// SNAP_A/SNAP_B together with a one-cycle VALID pulse.
// Optional feature macro: IOHOST_BANKB_EN. When defined, bank B
// (0x10-0x1F) is also read into SNAP_B. When undefined, only bank A is
// read and SNAP_B is tied to zero.
module ioctrl_host #(
  parameter int UPD_LEN = 2,
  parameter int SETTLE  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [3:0]  MODE,
  output logic        IO_EN,
  output logic        IO_WR,
  output logic [5:0]  IO_ADRS,
  output logic [7:0]  IO_WDATA,
  input  logic [7:0]  IO_RDATA,
  output logic        IO_UPDATE,
  output logic [63:0] SNAP_A,
  output logic [63:0] SNAP_B,
  output logic        VALID,
  output logic        BUSY,
  output logic        OVERRUN
);

`ifdef IOHOST_BANKB_EN
  localparam int NADDR = 32;
`else
  localparam int NADDR = 16;
`endif
  localparam int SHW = NADDR * 4;
  localparam logic [5:0] UPD_LAST    = 6'(UPD_LEN - 1);
  localparam logic [5:0] SETTLE_LAST = 6'(SETTLE - 1);
  localparam logic [5:0] ADR_LAST    = 6'(NADDR - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WMODE, S_UPD, S_WAIT, S_READ, S_DRAIN, S_DONE
  } state_t;

  state_t         state, state_nx;
  logic [5:0]     cnt, cnt_nx;
  logic           start_p1;
  logic           start_edge;
  logic [3:0]     mode_q;
  logic           load_mode;
  logic           capture;
  logic [5:0]     cap_slot;
  logic [SHW-1:0] shadow, shadow_nx;
  logic [63:0]    snap_a;
  logic           overrun_q;
  logic           unused_rdata_hi;

  // The chip only drives meaningful data on the low nibble.
  assign unused_rdata_hi = ^IO_RDATA[7:4];

  assign start_edge = START & ~start_p1;

  // Control state: FSM register, step counter, START history, sticky overrun.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      start_p1  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      start_p1 <= START;
      if (start_edge && (state != S_IDLE))
        overrun_q <= 1'b1;
    end
  end

  // Next-state and bus outputs. The read capture lags the address by one cycle.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    IO_EN     = 1'b0;
    IO_WR     = 1'b0;
    IO_ADRS   = '0;
    IO_UPDATE = 1'b0;
    load_mode = 1'b0;
    capture   = 1'b0;
    cap_slot  = '0;
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          load_mode = 1'b1;
          state_nx  = S_WMODE;
        end
      end
      S_WMODE: begin
        IO_EN    = 1'b1;
        IO_WR    = 1'b1;
        IO_ADRS  = 6'h08;
        cnt_nx   = '0;
        state_nx = S_UPD;
      end
      S_UPD: begin
        IO_UPDATE = 1'b1;
        if (cnt == UPD_LAST) begin
          cnt_nx   = '0;
          state_nx = S_WAIT;
        end else begin
          cnt_nx = cnt + 6'd1;
        end
      end
      S_WAIT: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nx   = '0;
          state_nx = S_READ;
        end else begin
          cnt_nx = cnt + 6'd1;
        end
      end
      S_READ: begin
        IO_EN    = 1'b1;
        IO_ADRS  = cnt;
        capture  = (cnt != 6'd0);
        cap_slot = cnt - 6'd1;
        if (cnt == ADR_LAST) begin
          cnt_nx   = '0;
          state_nx = S_DRAIN;
        end else begin
          cnt_nx = cnt + 6'd1;
        end
      end
      S_DRAIN: begin
        capture  = 1'b1;
        cap_slot = ADR_LAST;
        state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Shadow image with the current cycle's nibble merged in.
  always_comb begin
    shadow_nx = shadow;
    for (int i = 0; i < NADDR; i++) begin
      if (capture && (cap_slot == 6'(i)))
        shadow_nx[i*4 +: 4] = IO_RDATA[3:0];
    end
  end

`ifdef IOHOST_BANKB_EN
  logic [63:0] snap_b;
  assign SNAP_B = snap_b;
`else
  assign SNAP_B = '0;
`endif

  // Held mode, shadow capture, and snapshot publish. The publish uses the
  // merged image so the final nibble is visible together with VALID.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode_q <= '0;
      shadow <= '0;
      snap_a <= '0;
`ifdef IOHOST_BANKB_EN
      snap_b <= '0;
`endif
    end else begin
      if (load_mode)
        mode_q <= MODE;
      if (capture)
        shadow <= shadow_nx;
      if (state == S_DRAIN) begin
        snap_a <= shadow_nx[63:0];
`ifdef IOHOST_BANKB_EN
        snap_b <= shadow_nx[127:64];
`endif
      end
    end
  end

  assign IO_WDATA = IO_WR ? {4'h0, mode_q} : 8'h00;
  assign SNAP_A   = snap_a;
  assign VALID    = (state == S_DONE);
  assign BUSY     = (state != S_IDLE);
  assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_ioctrl_host.sv
// tb_ioctrl_host: bench for ioctrl_host with a nibble-RAM chip model and a
// frame-timeline reference model that is compared on every cycle.
// Honours IOHOST_BANKB_EN in the same way as the design.
module tb_ioctrl_host;
  localparam int UPD_LEN = 2;
  localparam int SETTLE  = 4;
`ifdef IOHOST_BANKB_EN
  localparam int          NADDR     = 32;
  localparam int          VALID_CYC = 41;
  localparam logic [63:0] SNAPB_LIT = 64'h0123456789ABCDEF;
  localparam bit          BANKB     = 1'b1;
`else
  localparam int          NADDR     = 16;
  localparam int          VALID_CYC = 25;
  localparam logic [63:0] SNAPB_LIT = 64'h0;
  localparam bit          BANKB     = 1'b0;
`endif
  localparam int R      = 2 + UPD_LEN + SETTLE;
  localparam int DONE_C = R + NADDR + 1;

  logic        CLK = 1'b0;
  logic        RESET, START;
  logic [3:0]  MODE;
  logic        IO_EN, IO_WR, IO_UPDATE;
  logic [5:0]  IO_ADRS;
  logic [7:0]  IO_WDATA, IO_RDATA;
  logic [63:0] SNAP_A, SNAP_B;
  logic        VALID, BUSY, OVERRUN;

  ioctrl_host #(.UPD_LEN(UPD_LEN), .SETTLE(SETTLE)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .MODE(MODE),
    .IO_EN(IO_EN), .IO_WR(IO_WR), .IO_ADRS(IO_ADRS), .IO_WDATA(IO_WDATA),
    .IO_RDATA(IO_RDATA), .IO_UPDATE(IO_UPDATE), .SNAP_A(SNAP_A),
    .SNAP_B(SNAP_B), .VALID(VALID), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int n_valid = 0;
  logic chk_on = 1'b0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
    end
  endtask

  // Chip model: nibble RAM, write on EN&WR, registered read on EN&~WR.
  logic [3:0] mema [16];
  logic [3:0] memb [16];
  logic [3:0] ld_a [16];
  logic [3:0] ld_b [16];
  logic       do_load = 1'b0;

  always @(posedge CLK) begin
    if (do_load) begin
      for (int i = 0; i < 16; i++) begin
        mema[i] <= ld_a[i];
        memb[i] <= ld_b[i];
      end
    end else if (IO_EN && IO_WR) begin
      if (IO_ADRS[5:4] == 2'b00) mema[IO_ADRS[3:0]] <= IO_WDATA[3:0];
      else if (IO_ADRS[5:4] == 2'b01) memb[IO_ADRS[3:0]] <= IO_WDATA[3:0];
    end
    if (IO_EN && !IO_WR)
      IO_RDATA <= {4'h5, IO_ADRS[4] ? memb[IO_ADRS[3:0]] : mema[IO_ADRS[3:0]]};
    else
      IO_RDATA <= 8'hEE;
  end

  function automatic logic [63:0] pack_a();
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = mema[i];
    return r;
  endfunction

  function automatic logic [63:0] pack_b();
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = memb[i];
    return r;
  endfunction

  // Reference model: m_c counts cycles since the accepted edge (0 = idle).
  int          m_c = 0;
  logic        m_pstart = 1'b0;
  logic [3:0]  m_mode = 4'h0;
  logic        m_ovr = 1'b0;
  logic [63:0] m_snap_a = 64'h0;
  logic [63:0] m_snap_b = 64'h0;
  logic        m_edge;
  assign m_edge = START && !m_pstart;

  always @(posedge CLK) begin
    if (RESET) begin
      m_c      <= 0;
      m_pstart <= 1'b0;
      m_mode   <= 4'h0;
      m_ovr    <= 1'b0;
      m_snap_a <= 64'h0;
      m_snap_b <= 64'h0;
    end else begin
      m_pstart <= START;
      if (m_c == 0) begin
        if (m_edge) begin
          m_c    <= 1;
          m_mode <= MODE;
        end
      end else begin
        if (m_edge) m_ovr <= 1'b1;
        m_c <= (m_c == DONE_C) ? 0 : m_c + 1;
        if (m_c == DONE_C - 1) begin
          m_snap_a <= pack_a();
          m_snap_b <= BANKB ? pack_b() : 64'h0;
        end
      end
    end
  end

  logic       e_rd, e_en, e_wr, e_upd, e_valid, e_busy;
  logic [5:0] e_adrs;
  logic [7:0] e_wdata;
  always_comb begin
    e_rd    = (m_c >= R) && (m_c < R + NADDR);
    e_en    = (m_c == 1) || e_rd;
    e_wr    = (m_c == 1);
    e_adrs  = (m_c == 1) ? 6'h08 : (e_rd ? 6'(m_c - R) : 6'h00);
    e_wdata = (m_c == 1) ? {4'h0, m_mode} : 8'h00;
    e_upd   = (m_c >= 2) && (m_c <= 1 + UPD_LEN);
    e_valid = (m_c == DONE_C);
    e_busy  = (m_c != 0);
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge CLK) begin
    if (chk_on) begin
      check("IO_EN", 64'(IO_EN), 64'(e_en));
      check("IO_WR", 64'(IO_WR), 64'(e_wr));
      check("IO_ADRS", 64'(IO_ADRS), 64'(e_adrs));
      check("IO_WDATA", 64'(IO_WDATA), 64'(e_wdata));
      check("IO_UPDATE", 64'(IO_UPDATE), 64'(e_upd));
      check("VALID", 64'(VALID), 64'(e_valid));
      check("BUSY", 64'(BUSY), 64'(e_busy));
      check("OVERRUN", 64'(OVERRUN), 64'(m_ovr));
      check("SNAP_A", SNAP_A, m_snap_a);
      check("SNAP_B", SNAP_B, m_snap_b);
      if (VALID) n_valid <= n_valid + 1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Advance from cycle t0 until VALID is seen or the budget runs out.
  task automatic wait_valid(input int t0, output int t);
    t = t0;
    while (!VALID && t < VALID_CYC + 30) begin
      tick();
      t++;
    end
  endtask

  task automatic load_pattern(input bit rnd);
    for (int i = 0; i < 16; i++) begin
      ld_a[i] = rnd ? 4'($urandom_range(0, 15)) : 4'(i);
      ld_b[i] = rnd ? 4'($urandom_range(0, 15)) : 4'(15 - i);
    end
    do_load = 1'b1;
    tick();
    do_load = 1'b0;
  endtask

  initial begin
    int t;
    int nv0;
    RESET = 1'b1;
    START = 1'b0;
    MODE  = 4'h0;
    tick();
    chk_on = 1'b1;
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_en", 64'(IO_EN), 64'd0);
    check("rst_snap_a", SNAP_A, 64'h0);
    check("rst_valid", 64'(VALID), 64'd0);
    check("rst_overrun", 64'(OVERRUN), 64'd0);
    tick();
    RESET = 1'b0;
    load_pattern(1'b0);
    tick();

    // Frame with MODE=8, mema[i]=i
    MODE = 4'h8;
    START = 1'b1;
    tick();
    check("f1_wr_c1", 64'(IO_EN & IO_WR), 64'd1);
    check("f1_adrs_c1", 64'(IO_ADRS), 64'h08);
    check("f1_wdata_c1", 64'(IO_WDATA), 64'h08);
    tick();
    check("f1_upd_c2", 64'(IO_UPDATE), 64'd1);
    tick();
    check("f1_upd_c3", 64'(IO_UPDATE), 64'd1);
    tick();
    check("f1_upd_c4", 64'(IO_UPDATE), 64'd0);
    wait_valid(4, t);
    check("f1_valid_cyc", 64'(t), 64'(VALID_CYC));
    check("f1_snap_a", SNAP_A, 64'hFEDCBA9876543210);
    check("f1_snap_b", SNAP_B, SNAPB_LIT);
    START = 1'b0;
    repeat (3) tick();

    // MODE changes during the write cycle; held value must be written
    MODE = 4'h8;
    START = 1'b1;
    tick();
    MODE = 4'h3;
    #1;
    check("f2_wdata_held", 64'(IO_WDATA), 64'h08);
    START = 1'b0;
    wait_valid(1, t);
    check("f2_valid_cyc", 64'(t), 64'(VALID_CYC));
    check("f2_snap_a", SNAP_A, 64'hFEDCBA9876543210);
    repeat (3) tick();

    // Second edge at cycle 10 sets OVERRUN and is not accepted
    nv0 = n_valid;
    MODE = 4'h8;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (9) tick();
    START = 1'b1;
    wait_valid(10, t);
    check("f3_valid_cyc", 64'(t), 64'(VALID_CYC));
    check("f3_overrun", 64'(OVERRUN), 64'd1);
    repeat (40) tick();
    check("f3_one_valid", 64'(n_valid - nv0), 64'd1);
    START = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("f3_ovr_cleared", 64'(OVERRUN), 64'd0);
    tick();

    // START held high for 100 cycles gives one frame; re-arm after a low cycle
    nv0 = n_valid;
    START = 1'b1;
    repeat (100) tick();
    check("f4_held_one", 64'(n_valid - nv0), 64'd1);
    START = 1'b0;
    tick();
    START = 1'b1;
    tick();
    check("f4_rearm_wr", 64'(IO_WR), 64'd1);
    wait_valid(1, t);
    check("f4_rearm_cyc", 64'(t), 64'(VALID_CYC));
    START = 1'b0;
    repeat (3) tick();

    // Random RAM contents with a different mode nibble
    load_pattern(1'b1);
    MODE = 4'h5;
    START = 1'b1;
    wait_valid(0, t);
    check("f5_valid_cyc", 64'(t), 64'(VALID_CYC));
    START = 1'b0;
    repeat (3) tick();

    // Reset at cycle 15 aborts the frame without a VALID
    load_pattern(1'b0);
    MODE = 4'h8;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (9) tick();
    START = 1'b1;
    tick();
    check("f6_overrun_pre", 64'(OVERRUN), 64'd1);
    repeat (4) tick();
    nv0 = n_valid;
    RESET = 1'b1;
    START = 1'b0;
    tick();
    check("f6_busy", 64'(BUSY), 64'd0);
    check("f6_en", 64'(IO_EN), 64'd0);
    check("f6_snap_a", SNAP_A, 64'h0);
    check("f6_overrun", 64'(OVERRUN), 64'd0);
    RESET = 1'b0;
    repeat (50) tick();
    check("f6_no_valid", 64'(n_valid - nv0), 64'd0);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
